// File: rtl/xintf_pkg.sv
// Shared constants and FSM state type for the XINTF target register file.
package xintf_pkg;

    localparam int unsigned XINTF_AW = 16;
    localparam int unsigned XINTF_DW = 16;

    localparam logic [XINTF_DW-1:0] BAD_READ_DEFAULT = 16'hDEAD;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCommit,
        StHold
    } xintf_state_e;

endpackage

// File: rtl/xintf_target_if.sv
// XINTF control/address bundle; xd stays a plain inout on the target so the tri-state
// driver lives at module level.
interface xintf_target_if;
    import xintf_pkg::*;

    logic [XINTF_AW-1:0] xa;
    logic                xwen;
    logic                xrdn;
    logic                zone_n;
    logic                xready;

    modport master (output xa, output xwen, output xrdn, output zone_n, input xready);
    modport slave  (input xa, input xwen, input xrdn, input zone_n, output xready);

endinterface

// File: rtl/xintf_sync.sv
// N-bit two-flop synchroniser with a configurable reset value.
module xintf_sync #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= ResetVal;
            r_sync <= ResetVal;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/xintf_target.sv
// XINTF responder: zone-decoded register file with programmable wait states, a local
// access port and a write-notify strobe.
module xintf_target
    import xintf_pkg::*;
#(
    parameter logic [XINTF_AW-1:0] BASE_ADDR   = 16'h1000,
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         WAIT_CYCLES = 2,
    parameter logic [XINTF_DW-1:0] BAD_READ    = BAD_READ_DEFAULT,
    localparam int unsigned        IDXW        = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    xintf_target_if.slave       bus,
    inout  wire  [XINTF_DW-1:0] xd,
    input  logic [IDXW-1:0]     loc_addr,
    input  logic [XINTF_DW-1:0] loc_wdata,
    input  logic                loc_we,
    output logic [XINTF_DW-1:0] loc_rdata,
    output logic                wr_strobe,
    output logic [IDXW-1:0]     wr_index
);

    logic [2:0]          w_sync;
    logic                w_zone, w_wr, w_rd, w_start, w_bus_idle, w_hit;
    logic                w_latch, w_bus_we, w_rd_d, w_oe_d, w_xready_d;
    xintf_state_e        w_state_d;
    logic [3:0]          w_cnt_d;
    logic [XINTF_DW-1:0] w_rdata;

    xintf_state_e        r_state;
    logic [3:0]          r_cnt;
    logic                r_hit, r_rd, r_oe, r_xready, r_wr_strobe;
    logic [IDXW-1:0]     r_idx, r_wr_index;
    logic [XINTF_DW-1:0] r_wdata;
    logic [XINTF_DW-1:0] r_regs [NUM_REGS];

    // Strobes idle high, so the synchroniser resets to all ones.
    xintf_sync #(
        .Width    (3),
        .ResetVal (3'b111)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bus.zone_n, bus.xwen, bus.xrdn}),
        .o_q   (w_sync)
    );

    assign w_zone     = ~w_sync[2];
    assign w_wr       = ~w_sync[1];
    assign w_rd       = ~w_sync[0];
    assign w_start    = w_zone && (w_wr ^ w_rd);
    assign w_bus_idle = &w_sync;
    assign w_hit      = (bus.xa[XINTF_AW-1:IDXW] == BASE_ADDR[XINTF_AW-1:IDXW]);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_latch   = 1'b0;
        w_bus_we  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StWait;
                    w_cnt_d   = 4'(WAIT_CYCLES);
                    w_latch   = 1'b1;
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 4'd1;
                // A count of 0 or 1 means this is the last wait cycle.
                if (r_cnt <= 4'd1) begin
                    w_state_d = StCommit;
                end
            end
            StCommit: begin
                w_state_d = StHold;
                w_bus_we  = !r_rd && r_hit;
            end
            StHold: begin
                if (w_bus_idle) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_rd_d     = w_latch ? w_rd : r_rd;
        w_oe_d     = (w_state_d != StIdle) && w_rd_d;
        w_xready_d = (w_state_d != StWait) || (WAIT_CYCLES == 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_hit       <= 1'b0;
            r_rd        <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_oe        <= 1'b0;
            r_xready    <= 1'b1;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_rd        <= w_rd_d;
            r_oe        <= w_oe_d;
            r_xready    <= w_xready_d;
            r_wr_strobe <= w_bus_we;
            if (w_latch) begin
                r_hit   <= w_hit;
                r_idx   <= bus.xa[IDXW-1:0];
                r_wdata <= xd;
            end
            if (loc_we) begin
                r_regs[loc_addr] <= loc_wdata;
            end
            // Placed after the local write so a same-index collision resolves to the bus.
            if (w_bus_we) begin
                r_regs[r_idx] <= r_wdata;
                r_wr_index    <= r_idx;
            end
        end
    end

    assign w_rdata    = r_hit ? r_regs[r_idx] : BAD_READ;
    assign xd         = r_oe ? w_rdata : {XINTF_DW{1'bz}};
    assign bus.xready = r_xready;
    assign loc_rdata  = r_regs[loc_addr];
    assign wr_strobe  = r_wr_strobe;
    assign wr_index   = r_wr_index;

endmodule

// File: tb/tb_xintf_target.sv
// Randomised bench for xintf_target against a register-array reference model, plus a
// WAIT_CYCLES=0 instance.
module tb_xintf_target;

    logic        clk = 1'b0;
    logic        reset;
    int          n_vec = 0;
    int          n_err = 0;

    xintf_target_if bus_a ();
    xintf_target_if bus_b ();

    wire  [15:0] xd_a;
    wire  [15:0] xd_b;
    logic [15:0] tb_xd_a, tb_xd_b;
    logic        tb_drv_a, tb_drv_b;
    logic [3:0]  loc_addr_a, loc_addr_b, wr_index_a, wr_index_b;
    logic [15:0] loc_wdata_a, loc_wdata_b, loc_rdata_a, loc_rdata_b;
    logic        loc_we_a, loc_we_b, wr_strobe_a, wr_strobe_b;

    // Undriven bus reads back as all ones.
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup (xd_a[g]);
        pullup (xd_b[g]);
    end
    assign xd_a = tb_drv_a ? tb_xd_a : 16'hzzzz;
    assign xd_b = tb_drv_b ? tb_xd_b : 16'hzzzz;

    always #5 clk = ~clk;

    xintf_target #(.WAIT_CYCLES(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_a),
        .xd        (xd_a),
        .loc_addr  (loc_addr_a),
        .loc_wdata (loc_wdata_a),
        .loc_we    (loc_we_a),
        .loc_rdata (loc_rdata_a),
        .wr_strobe (wr_strobe_a),
        .wr_index  (wr_index_a)
    );

    xintf_target #(.WAIT_CYCLES(0)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_b),
        .xd        (xd_b),
        .loc_addr  (loc_addr_b),
        .loc_wdata (loc_wdata_b),
        .loc_we    (loc_we_b),
        .loc_rdata (loc_rdata_b),
        .wr_strobe (wr_strobe_b),
        .wr_index  (wr_index_b)
    );

    logic [15:0] model [16];
    int          last_idx;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic loc_chk(input int i);
        loc_addr_a = 4'(i);
        #1;
        check_eq($sformatf("loc_rdata[%0d]", i), {16'h0, loc_rdata_a}, {16'h0, model[i]});
    endtask

    task automatic loc_write(input int i, input logic [15:0] d);
        @(negedge clk);
        loc_addr_a  = 4'(i);
        loc_wdata_a = d;
        loc_we_a    = 1'b1;
        @(negedge clk);
        loc_we_a = 1'b0;
        model[i] = d;
    endtask

    task automatic a_access(input bit rd, input logic [15:0] addr, input logic [15:0] data,
                            input bit coll, input logic [15:0] coll_data);
        bit          hit, seen_low, coll_done;
        int          lows, pulses, idx;
        logic [15:0] rdv;
        hit = (addr[15:4] == 12'h100);
        idx = int'(addr[3:0]);
        lows = 0; pulses = 0; seen_low = 0; coll_done = 0; rdv = '0;
        @(negedge clk);
        bus_a.xa     = addr;
        bus_a.zone_n = 1'b0;
        if (rd) begin
            bus_a.xrdn = 1'b0;
        end else begin
            bus_a.xwen = 1'b0;
            tb_xd_a    = data;
            tb_drv_a   = 1'b1;
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            loc_we_a = 1'b0;
            if (!bus_a.xready) begin
                lows++;
                seen_low = 1;
            end else if (coll && seen_low && !coll_done) begin
                // First ready cycle after the wait phase is the commit cycle.
                loc_addr_a  = 4'(idx);
                loc_wdata_a = coll_data;
                loc_we_a    = 1'b1;
                coll_done   = 1;
            end
            if (wr_strobe_a) pulses++;
            if (c == 10) rdv = xd_a;
        end
        bus_a.zone_n = 1'b1;
        bus_a.xwen   = 1'b1;
        bus_a.xrdn   = 1'b1;
        tb_drv_a     = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_strobe_a) pulses++;
        end
        check_eq("xd_release", {16'h0, xd_a}, 32'h0000_FFFF);
        repeat (2) @(negedge clk);
        check_eq("xready_low_cycles", lows, 2);
        if (!rd && hit) begin
            model[idx] = data;
            last_idx   = idx;
        end
        check_eq("wr_strobe_pulses", pulses, (!rd && hit) ? 1 : 0);
        check_eq("wr_index", {28'h0, wr_index_a}, last_idx);
        if (rd) check_eq("rd_data", {16'h0, rdv}, {16'h0, hit ? model[idx] : 16'hDEAD});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int          b_lows, b_pulses, b_drv;
        logic [15:0] addr, rdv;
        bit          seen;
        reset = 1'b1;
        {bus_a.zone_n, bus_a.xwen, bus_a.xrdn} = 3'b111;
        {bus_b.zone_n, bus_b.xwen, bus_b.xrdn} = 3'b111;
        bus_a.xa = '0; bus_b.xa = '0;
        tb_drv_a = 0; tb_drv_b = 0; tb_xd_a = '0; tb_xd_b = '0;
        loc_addr_a = '0; loc_addr_b = '0; loc_wdata_a = '0; loc_wdata_b = '0;
        loc_we_a = 0; loc_we_b = 0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        last_idx = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_eq("rst_xready", bus_a.xready, 1);
        check_eq("rst_wr_strobe", wr_strobe_a, 0);
        check_eq("rst_wr_index", {28'h0, wr_index_a}, 0);
        check_eq("rst_xd", {16'h0, xd_a}, 32'h0000_FFFF);
        for (int i = 0; i < 16; i++) loc_chk(i);

        a_access(0, 16'h1000, 16'h0AA0, 0, '0);
        loc_chk(0);
        loc_write(3, 16'hBEEF);
        a_access(1, 16'h1003, '0, 0, '0);
        a_access(1, 16'h2005, '0, 0, '0);
        a_access(0, 16'h2005, 16'h1234, 0, '0);
        for (int i = 0; i < 16; i++) loc_chk(i);
        a_access(0, 16'h1007, 16'h5555, 1, 16'hAAAA);
        loc_chk(7);

        // Reset in the middle of the wait phase of a write to index 2.
        @(negedge clk);
        bus_a.xa = 16'h1002; bus_a.zone_n = 0; bus_a.xwen = 0;
        tb_xd_a = 16'h1111; tb_drv_a = 1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (!bus_a.xready) seen = 1;
        end
        check_eq("wait_reached", seen, 1);
        reset = 1'b1;
        {bus_a.zone_n, bus_a.xwen, bus_a.xrdn} = 3'b111;
        tb_drv_a = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        last_idx = 0;
        check_eq("midrst_xready", bus_a.xready, 1);
        check_eq("midrst_xd", {16'h0, xd_a}, 32'h0000_FFFF);
        check_eq("midrst_wr_strobe", wr_strobe_a, 0);
        loc_chk(2);
        repeat (3) @(negedge clk);
        a_access(0, 16'h1002, 16'h2222, 0, '0);
        loc_chk(2);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 9) < 3) loc_write($urandom_range(0, 15), 16'($urandom));
            addr = 16'($urandom);
            if ($urandom_range(0, 9) < 7) addr = {12'h100, addr[3:0]};
            else if (addr[15:4] == 12'h100) addr[15] = 1'b1;
            a_access($urandom_range(0, 1) == 1, addr, 16'($urandom), 0, '0);
            loc_chk($urandom_range(0, 15));
        end

        // WAIT_CYCLES=0 instance: write, read back, then both strobes low together.
        b_lows = 0; b_pulses = 0;
        @(negedge clk);
        bus_b.xa = 16'h1004; bus_b.zone_n = 0; bus_b.xwen = 0;
        tb_xd_b = 16'h4321; tb_drv_b = 1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!bus_b.xready) b_lows++;
            if (wr_strobe_b) b_pulses++;
        end
        {bus_b.zone_n, bus_b.xwen, bus_b.xrdn} = 3'b111;
        tb_drv_b = 0;
        repeat (5) @(negedge clk);
        check_eq("w0_wr_xready_low", b_lows, 0);
        check_eq("w0_wr_pulses", b_pulses, 1);
        check_eq("w0_wr_index", {28'h0, wr_index_b}, 4);
        loc_addr_b = 4'd4;
        #1;
        check_eq("w0_loc_rdata", {16'h0, loc_rdata_b}, 32'h0000_4321);

        b_lows = 0; rdv = '0;
        @(negedge clk);
        bus_b.zone_n = 0; bus_b.xrdn = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (!bus_b.xready) b_lows++;
            if (c == 10) rdv = xd_b;
        end
        {bus_b.zone_n, bus_b.xwen, bus_b.xrdn} = 3'b111;
        repeat (3) @(negedge clk);
        check_eq("w0_rd_xready_low", b_lows, 0);
        check_eq("w0_rd_data", {16'h0, rdv}, 32'h0000_4321);
        check_eq("w0_rd_release", {16'h0, xd_b}, 32'h0000_FFFF);
        repeat (2) @(negedge clk);

        b_drv = 0; b_pulses = 0;
        @(negedge clk);
        bus_b.zone_n = 0; bus_b.xwen = 0; bus_b.xrdn = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (xd_b != 16'hFFFF) b_drv++;
            if (wr_strobe_b) b_pulses++;
        end
        {bus_b.zone_n, bus_b.xwen, bus_b.xrdn} = 3'b111;
        repeat (3) @(negedge clk);
        check_eq("w0_both_low_drive", b_drv, 0);
        check_eq("w0_both_low_pulses", b_pulses, 0);
        #1;
        check_eq("w0_both_low_reg", {16'h0, loc_rdata_b}, 32'h0000_4321);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
